// File: rtl/bank_response_arbiter_if.sv
// Response-merge channel: NUM_PORTS packed requester streams in, one registered response stream out.
// The arbiter uses the slave modport; whoever drives requests and consumes responses uses master.
interface bank_response_arbiter_if #(
  parameter int NUM_PORTS = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 32
);
  localparam int SRC_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS*ADDR_W-1:0] in_addr;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS*ID_W-1:0]   in_request_id;
  logic                        out_valid;
  logic                        out_ready;
  logic [ADDR_W-1:0]           out_addr;
  logic [DATA_W-1:0]           out_data;
  logic [ID_W-1:0]             out_request_id;
  logic [SRC_W-1:0]            out_src;
  logic [63:0]                 out_cycle;

  modport master (
    output in_valid, in_addr, in_data, in_request_id, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_request_id, out_src, out_cycle
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_request_id, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_request_id, out_src, out_cycle
  );
endinterface

// File: rtl/bank_response_arbiter.sv
// Round-robin merge of bank responses into a one-entry output register (1-cycle latency, holds under !out_ready),
// cycle-stamped from the free-running globalCycle. Define RESP_ARB_STATS_EN for grant_count/max_wait.
module bank_response_arbiter #(
  parameter int          NUM_PORTS    = 8,
  parameter int          ADDR_W       = 32,
  parameter int          DATA_W       = 32,
  parameter int          ID_W         = 32,
  parameter logic [63:0] CYCLE_PRESET = 64'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  bank_response_arbiter_if.slave bus,
  output logic [63:0]            globalCycle
`ifdef RESP_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] grant_count,
  output logic [31:0]             max_wait
`endif
);
  localparam int SRC_W = $clog2(NUM_PORTS);

  logic [SRC_W-1:0]  last;
  logic [SRC_W-1:0]  cand;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_found;
  logic              can_load;
  logic              accept;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   sel_id;

  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ID_W-1:0]   out_id_q;
  logic [SRC_W-1:0]  out_src_q;
  logic [63:0]       out_cycle_q;

  // Search starts one past the last winner so the previous grantee drops to lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = SRC_W'((int'(last) + off) % NUM_PORTS);
      if (!gnt_found && bus.in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign can_load = !out_valid_q || bus.out_ready;
  assign accept   = !reset && can_load && gnt_found;

  always_comb begin
    bus.in_ready = '0;
    if (accept)
      bus.in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_id   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx == SRC_W'(p)) begin
        sel_addr = bus.in_addr[p*ADDR_W +: ADDR_W];
        sel_data = bus.in_data[p*DATA_W +: DATA_W];
        sel_id   = bus.in_request_id[p*ID_W +: ID_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      globalCycle <= CYCLE_PRESET;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_src_q   <= '0;
      out_cycle_q <= '0;
      last        <= SRC_W'(NUM_PORTS - 1);
    end else begin
      globalCycle <= globalCycle + 64'd1;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= sel_addr;
        out_data_q  <= sel_data;
        out_id_q    <= sel_id;
        out_src_q   <= gnt_idx;
        out_cycle_q <= globalCycle;
        last        <= gnt_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_addr       = out_addr_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_request_id = out_id_q;
  assign bus.out_src        = out_src_q;
  assign bus.out_cycle      = out_cycle_q;

`ifdef RESP_ARB_STATS_EN
  logic [31:0] wait_run  [NUM_PORTS];
  logic [31:0] wait_next [NUM_PORTS];
  logic [31:0] wait_peak;

  // A port's run restarts whenever it is either idle or accepted.
  always_comb begin
    wait_peak = max_wait;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wait_next[p] = '0;
      if (bus.in_valid[p] && !bus.in_ready[p])
        wait_next[p] = (wait_run[p] == 32'hFFFF_FFFF) ? wait_run[p] : wait_run[p] + 32'd1;
      if (wait_next[p] > wait_peak)
        wait_peak = wait_next[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count <= '0;
      max_wait    <= '0;
      for (int p = 0; p < NUM_PORTS; p++)
        wait_run[p] <= '0;
    end else begin
      max_wait <= wait_peak;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wait_run[p] <= wait_next[p];
        if (accept && gnt_idx == SRC_W'(p) && grant_count[p*32 +: 32] != 32'hFFFF_FFFF)
          grant_count[p*32 +: 32] <= grant_count[p*32 +: 32] + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bank_response_arbiter.sv
// Scoreboard bench: a behavioural round-robin model predicts grants and pushes expected responses,
// which are popped and compared when the arbiter presents them; a 2-port instance covers the cycle wrap.
module tb_bank_response_arbiter;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] id;
    int          src;
    logic [63:0] cyc;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        rst2;
  logic [63:0] globalCycle;
  logic [63:0] gc2;
`ifdef RESP_ARB_STATS_EN
  logic [255:0] gcnt;
  logic [31:0]  mwait;
  logic [63:0]  gcnt2;
  logic [31:0]  mwait2;
`endif

  bank_response_arbiter_if #(.NUM_PORTS(8)) bus ();
  bank_response_arbiter_if #(.NUM_PORTS(2)) bus2 ();

  bank_response_arbiter #(.NUM_PORTS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .globalCycle(globalCycle)
`ifdef RESP_ARB_STATS_EN
    ,
    .grant_count(gcnt),
    .max_wait   (mwait)
`endif
  );

  bank_response_arbiter #(.NUM_PORTS(2), .CYCLE_PRESET(64'hFFFF_FFFF_FFFF_FFFD)) dut2 (
    .clk        (clk),
    .reset      (rst2),
    .bus        (bus2),
    .globalCycle(gc2)
`ifdef RESP_ARB_STATS_EN
    ,
    .grant_count(gcnt2),
    .max_wait   (mwait2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  vld;
  int          rem    [8];
  logic [31:0] addr_p [8];
  logic [31:0] data_p [8];
  logic [31:0] id_p   [8];
  int          serial = 0;
  logic        m_ov   = 1'b0;
  int          last_m = 7;
  logic [63:0] cyc    = 64'd0;
  resp_t       q[$];
  resp_t       cur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bus();
    bus.in_valid = vld;
    for (int p = 0; p < 8; p++) begin
      bus.in_addr[p*32 +: 32]       = addr_p[p];
      bus.in_data[p*32 +: 32]       = data_p[p];
      bus.in_request_id[p*32 +: 32] = id_p[p];
    end
  endtask

  task automatic refill(input int p);
    if (rem[p] > 0) begin
      vld[p]    = 1'b1;
      addr_p[p] = $urandom;
      data_p[p] = $urandom;
      id_p[p]   = {8'(p), 24'(serial)};
      serial++;
    end else begin
      vld[p] = 1'b0;
    end
  endtask

  task automatic start_port(input int p, input int n);
    rem[p] = n;
    refill(p);
  endtask

  // Called at a negedge with inputs set; checks this cycle, advances the model across the next posedge.
  task automatic tick_cycle();
    int         g;
    logic       load;
    logic [7:0] exp_rdy;
    drive_bus();
    #1;
    g = -1;
    if (!reset && (!m_ov || bus.out_ready)) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (last_m + k) % 8;
        if (g < 0 && vld[c[2:0]]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g[2:0]] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("globalCycle", globalCycle, cyc);
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_addr", 64'(bus.out_addr), 64'(cur.addr));
      chk("out_data", 64'(bus.out_data), 64'(cur.data));
      chk("out_request_id", 64'(bus.out_request_id), 64'(cur.id));
      chk("out_src", 64'(bus.out_src), 64'(cur.src));
      chk("out_cycle", bus.out_cycle, cur.cyc);
    end
    load = 1'b0;
    if (reset) begin
      m_ov   = 1'b0;
      cyc    = 64'd0;
      last_m = 7;
      q.delete();
    end else begin
      if (g >= 0) begin
        load = 1'b1;
        q.push_back('{addr_p[g], data_p[g], id_p[g], g, cyc});
        last_m = g;
        m_ov   = 1'b1;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      cyc = cyc + 64'd1;
    end
    @(posedge clk);
    @(negedge clk);
    if (load) begin
      cur = q.pop_front();
      if (rem[g] > 0) rem[g]--;
      refill(g);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while ((vld != 8'd0 || m_ov) && guard < 200) begin
      tick_cycle();
      guard++;
    end
    chk("drain_timeout", 64'(vld != 8'd0 || m_ov), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rst2  = 1'b1;
    vld   = '0;
    for (int p = 0; p < 8; p++) begin
      rem[p] = 0; addr_p[p] = '0; data_p[p] = '0; id_p[p] = '0;
    end
    bus.out_ready      = 1'b1;
    bus2.in_valid      = '0;
    bus2.in_addr       = '0;
    bus2.in_data       = '0;
    bus2.in_request_id = '0;
    bus2.out_ready     = 1'b1;
    drive_bus();
    @(posedge clk);
    @(negedge clk);

    // reset held, then idle counting
    repeat (3) tick_cycle();
    reset = 1'b0;
    chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
    chk("rst_out_cycle", bus.out_cycle, 64'd0);
    chk("rst_out_src", 64'(bus.out_src), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_gc", globalCycle, 64'(i));
      tick_cycle();
    end

    // single request from port 3 at cycle 10
    while (cyc != 64'd10 && cyc < 64'd20) tick_cycle();
    rem[3] = 1; vld[3] = 1'b1; addr_p[3] = 32'h40; id_p[3] = 32'd7; data_p[3] = 32'hDEAD_0003;
    drive_bus();
    #1;
    chk("t2_in_ready", 64'(bus.in_ready), 64'h08);
    tick_cycle();
    chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_out_addr", 64'(bus.out_addr), 64'h40);
    chk("t2_out_id", 64'(bus.out_request_id), 64'd7);
    chk("t2_out_src", 64'(bus.out_src), 64'd3);
    chk("t2_out_cycle", bus.out_cycle, 64'd10);
    drain();

    // all ports valid from a fresh pointer
    reset = 1'b1;
    repeat (2) tick_cycle();
    reset = 1'b0;
    for (int p = 0; p < 8; p++) start_port(p, 9);
    tick_cycle();
    for (int i = 0; i < 9; i++) begin
      chk("t3_src", 64'(bus.out_src), 64'(i % 8));
      chk("t3_valid", 64'(bus.out_valid), 64'd1);
      tick_cycle();
    end

    // stall, then release with no bubble
    bus.out_ready = 1'b0;
    repeat (5) tick_cycle();
    bus.out_ready = 1'b1;
    tick_cycle();
    chk("t4_nobubble", 64'(bus.out_valid), 64'd1);
    chk("t4_src", 64'(bus.out_src), 64'd2);
    drain();

    // random traffic and backpressure, ending with a reset mid-transfer
    for (int n = 0; n < 300; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 8; p++)
        if (!vld[p] && $urandom_range(0, 3) == 0) start_port(p, int'($urandom_range(1, 4)));
      tick_cycle();
    end
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick_cycle();
    reset = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

`ifdef RESP_ARB_STATS_EN
    reset = 1'b1;
    repeat (2) tick_cycle();
    reset = 1'b0;
    start_port(2, 3);
    repeat (3) tick_cycle();
    chk("t6_grant2", 64'(gcnt[2*32 +: 32]), 64'd3);
    bus.out_ready = 1'b0;
    start_port(5, 1);
    repeat (4) tick_cycle();
    chk("t6_maxwait_ge4", 64'(mwait >= 32'd4), 64'd1);
    reset = 1'b1;
    tick_cycle();
    reset = 1'b0;
    chk("t6_rst_grant", 64'(gcnt != '0), 64'd0);
    chk("t6_rst_maxwait", 64'(mwait), 64'd0);
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    drain();
`endif

    // globalCycle wrap on the preset instance
    rst2 = 1'b0;
    chk("wrap_gc_fd", gc2, 64'hFFFF_FFFF_FFFF_FFFD);
    @(posedge clk); @(negedge clk);
    chk("wrap_gc_fe", gc2, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); @(negedge clk);
    chk("wrap_gc_ff", gc2, 64'hFFFF_FFFF_FFFF_FFFF);
    bus2.in_valid                = 2'b10;
    bus2.in_addr[32 +: 32]       = 32'h0000_ABCD;
    bus2.in_request_id[32 +: 32] = 32'h55;
    #1;
    chk("wrap_in_ready", 64'(bus2.in_ready), 64'h2);
    @(posedge clk); @(negedge clk);
    bus2.in_valid = 2'b00;
    chk("wrap_gc_zero", gc2, 64'd0);
    chk("wrap_out_valid", 64'(bus2.out_valid), 64'd1);
    chk("wrap_out_cycle", bus2.out_cycle, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_out_src", 64'(bus2.out_src), 64'd1);
    chk("wrap_out_addr", 64'(bus2.out_addr), 64'h0000_ABCD);
    chk("wrap_out_id", 64'(bus2.out_request_id), 64'h55);
    @(posedge clk); @(negedge clk);
    chk("wrap_gc_one", gc2, 64'd1);
    chk("wrap_out_idle", 64'(bus2.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
